// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: word fetch, halfword split, small PC-tagged buffer.
// One memory request in flight at most; redirects flush and restart fetch.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  n_reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [15:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  fifo_empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic [15:0]           ibuf_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pbuf_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    logic [ADDR_WIDTH-1:0] redir_pc;
    logic [ADDR_WIDTH-1:0] pc_word;
    logic [ADDR_WIDTH-1:0] pc_hi_half;
    logic [ADDR_WIDTH-1:0] next_word;
    logic                  can_req;
    logic                  ack_ok;
    logic                  two_half;
    logic [1:0]            push_cnt;
    logic                  pop;
    logic [15:0]           push_d0;
    logic [PW-1:0]         wr_ptr_p1;

    // Halfword addresses only: bit0 of the target is dropped.
    assign redir_pc   = redirect_pc & ~ONE;
    assign pc_word    = {fetch_pc_q[ADDR_WIDTH-1:2], 2'b00};
    assign pc_hi_half = {fetch_pc_q[ADDR_WIDTH-1:2], 2'b10};
    assign next_word  = pc_word + FOUR;

    // A request needs room for both halves of a word.
    assign can_req  = (count_q <= CW'(FIFO_DEPTH - 2));
    assign ack_ok   = (state_q == S_REQ) && mem_ack && !redirect_valid;
    assign two_half = !fetch_pc_q[1];
    assign push_cnt = !ack_ok ? 2'd0 : (two_half ? 2'd2 : 2'd1);
    assign push_d0  = two_half ? mem_rdata[31:16] : mem_rdata[15:0];
    assign wr_ptr_p1 = wr_ptr_q + PW'(1);

    assign fifo_empty  = (count_q == '0);
    assign instr_valid = !fifo_empty && !stall && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign instr       = ibuf_q[rd_ptr_q];
    assign instr_pc    = pbuf_q[rd_ptr_q];
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    assign count_d = count_q + CW'(push_cnt) - CW'(pop);

    // Fetch sequencer: issue, hold until ack, drop data across redirects.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redir_pc;
                    end else if (can_req) begin
                        state_q    <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_word;
                    end
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redir_pc;
                        if (mem_ack) begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end else if (mem_ack) begin
                        fetch_pc_q <= next_word;
                        state_q    <= S_IDLE;
                        mem_req_q  <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redir_pc;
                    end
                    if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Instruction buffer: push one or two halves on ack, pop on handshake.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ibuf_q[i] <= '0;
                pbuf_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (ack_ok) begin
                ibuf_q[wr_ptr_q] <= push_d0;
                pbuf_q[wr_ptr_q] <= fetch_pc_q;
                if (two_half) begin
                    ibuf_q[wr_ptr_p1] <= mem_rdata[15:0];
                    pbuf_q[wr_ptr_p1] <= pc_hi_half;
                end
            end
            wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Hand-computed expectations, immediate assertions at each check point.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [31:0] instr_pc;
    logic        fifo_empty;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(
        .ADDR_WIDTH(32),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fifo_empty    (fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ack(input logic [31:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        n_reset        = 1'b0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        instr_ready    = 1'b0;
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        // T1: first fetch from reset PC
        tick();
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_addr", mem_addr, 32'h0);
        tick();
        chk("t1_req_held", 32'(mem_req), 32'd1);
        ack(32'h1234_5678);
        chk("t1_req_drop", 32'(mem_req), 32'd0);
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_instr", 32'(instr), 32'h1234);
        chk("t1_pc", instr_pc, 32'h0);

        // T2: fill without popping
        tick();
        chk("t2_req", 32'(mem_req), 32'd1);
        chk("t2_addr", mem_addr, 32'h4);
        ack(32'hAAAA_BBBB);
        for (int i = 0; i < 3; i++) tick();
        chk("t2_full_noreq", 32'(mem_req), 32'd0);
        chk("t2_head", 32'(instr), 32'h1234);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t1_instr2", 32'(instr), 32'h5678);
        chk("t1_pc2", instr_pc, 32'h2);
        tick();
        chk("t2_one_free_noreq", 32'(mem_req), 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_instr3", 32'(instr), 32'hAAAA);
        chk("t2_pc3", instr_pc, 32'h4);
        tick();
        chk("t2_req2", 32'(mem_req), 32'd1);
        chk("t2_addr2", mem_addr, 32'h8);

        // T4 + T3: redirect with request outstanding, odd-halfword target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        #1;
        chk("t4_valid_mask", 32'(instr_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("t4_flushed", 32'(fifo_empty), 32'd1);
        chk("t4_req_held", 32'(mem_req), 32'd1);
        chk("t4_addr_held", mem_addr, 32'h8);
        tick();
        tick();
        ack(32'hDEAD_BEEF);
        chk("t4_req_drop", 32'(mem_req), 32'd0);
        chk("t4_dropped", 32'(fifo_empty), 32'd1);
        tick();
        chk("t3_req", 32'(mem_req), 32'd1);
        chk("t3_addr", mem_addr, 32'h100);
        ack(32'h1111_2222);
        chk("t3_instr", 32'(instr), 32'h2222);
        chk("t3_pc", instr_pc, 32'h102);
        tick();
        chk("t3_next_addr", mem_addr, 32'h104);

        // T5: stall masks valid and blocks pops
        stall       = 1'b1;
        instr_ready = 1'b1;
        ack(32'h3333_4444);
        chk("t5_stall_valid", 32'(instr_valid), 32'd0);
        tick();
        tick();
        chk("t5_stall_head", 32'(instr), 32'h2222);
        chk("t5_stall_pc", instr_pc, 32'h102);
        stall = 1'b0;
        #1;
        chk("t5_resume_valid", 32'(instr_valid), 32'd1);
        tick();
        chk("t5_instr_a", 32'(instr), 32'h3333);
        chk("t5_pc_a", instr_pc, 32'h104);
        tick();
        instr_ready = 1'b0;
        chk("t5_instr_b", 32'(instr), 32'h4444);
        chk("t5_pc_b", instr_pc, 32'h106);
        chk("t5_req", 32'(mem_req), 32'd1);
        chk("t5_addr", mem_addr, 32'h108);

        // T6: redirect coincident with ack, then wrap at top of space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFD;
        ack(32'hBAD0_BAD0);
        redirect_valid = 1'b0;
        chk("t6_flushed", 32'(fifo_empty), 32'd1);
        chk("t6_req_drop", 32'(mem_req), 32'd0);
        tick();
        chk("t6_addr", mem_addr, 32'hFFFF_FFFC);
        ack(32'h5555_6666);
        chk("t6_instr_a", 32'(instr), 32'h5555);
        chk("t6_pc_a", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t6_instr_b", 32'(instr), 32'h6666);
        chk("t6_pc_b", instr_pc, 32'hFFFF_FFFE);
        chk("t6_wrap_req", 32'(mem_req), 32'd1);
        chk("t6_wrap_addr", mem_addr, 32'h0);

        // Asynchronous reset mid-request
        n_reset = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_empty", 32'(fifo_empty), 32'd1);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_valid", 32'(instr_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
